// File: rtl/clk_div_multi.sv
// clk_div_multi: NCH independent, runtime-programmable 50%-duty clock dividers.
// Each channel counts half-periods of clk_w5 and toggles clk_out. A rewritten
// half-period is held pending and only adopted at a high->low boundary (or
// while parked), so a divided clock never shows a shortened phase.
module clk_div_multi #(
    parameter int NCH      = 2,
    parameter int CH_W     = 1,
    parameter int CNT_W    = 16,
    parameter int DEF_HALF = 25
) (
    input  logic             clk_w5,
    input  logic             reset_b,
    input  logic [NCH-1:0]   en,
    input  logic             div_wr,
    input  logic [CH_W-1:0]  div_ch,
    input  logic [CNT_W-1:0] div_val,
    output logic             div_ack,
    output logic             div_err,
    output logic [NCH-1:0]   clk_out,
    output logic [NCH-1:0]   tick
);

    localparam logic [CNT_W-1:0] DEF_HALF_C = CNT_W'(DEF_HALF);
    localparam logic [CNT_W-1:0] ONE_C      = CNT_W'(1);

    typedef enum logic {
        PARKED = 1'b0,
        RUN    = 1'b1
    } state_e;

    state_e           state      [NCH];
    state_e           state_nxt  [NCH];
    logic [CNT_W-1:0] q          [NCH];
    logic [CNT_W-1:0] q_nxt      [NCH];
    logic [CNT_W-1:0] half       [NCH];
    logic [CNT_W-1:0] half_nxt   [NCH];
    logic [CNT_W-1:0] pend       [NCH];
    logic [CNT_W-1:0] pend_nxt   [NCH];
    logic [NCH-1:0]   pend_v;
    logic [NCH-1:0]   pend_v_nxt;
    logic [NCH-1:0]   clk_nxt;
    logic [NCH-1:0]   tick_nxt;
    logic [NCH-1:0]   apply;
    logic [NCH-1:0]   wr_hit;
    logic             wr_ok;

    // Decode the divisor write: legal channel and non-zero half-period only.
    always_comb begin
        wr_hit = '0;
        wr_ok  = div_wr && (32'(div_ch) < NCH) && (div_val != '0);
        for (int i = 0; i < NCH; i++) begin
            wr_hit[i] = wr_ok && (32'(div_ch) == i);
        end
    end

    // Per-channel next state: park/run control, half-period counting,
    // boundary-synchronised divisor adoption and pending-write capture.
    always_comb begin
        state_nxt  = state;
        q_nxt      = q;
        half_nxt   = half;
        pend_nxt   = pend;
        pend_v_nxt = pend_v;
        clk_nxt    = clk_out;
        tick_nxt   = '0;
        apply      = '0;
        for (int i = 0; i < NCH; i++) begin
            unique case (state[i])
                PARKED: begin
                    // Parked: output low, counter cleared, divisor may change freely.
                    q_nxt[i]   = '0;
                    clk_nxt[i] = 1'b0;
                    apply[i]   = pend_v[i];
                    if (en[i]) begin
                        state_nxt[i] = RUN;
                    end
                end
                RUN: begin
                    if (!en[i] && !clk_out[i]) begin
                        // Disabled while low: park now, stretching the low phase.
                        state_nxt[i] = PARKED;
                        q_nxt[i]     = '0;
                    end else if (q[i] == half[i] - ONE_C) begin
                        q_nxt[i]   = '0;
                        clk_nxt[i] = !clk_out[i];
                        if (clk_out[i]) begin
                            // High->low is the period boundary.
                            apply[i] = pend_v[i];
                            if (!en[i]) begin
                                state_nxt[i] = PARKED;
                            end
                        end else begin
                            tick_nxt[i] = 1'b1;
                        end
                    end else begin
                        q_nxt[i] = q[i] + ONE_C;
                    end
                end
            endcase
            if (apply[i]) begin
                half_nxt[i]   = pend[i];
                pend_v_nxt[i] = 1'b0;
            end
            // A write on the adoption edge stays pending for the next boundary.
            if (wr_hit[i]) begin
                pend_nxt[i]   = div_val;
                pend_v_nxt[i] = 1'b1;
            end
        end
    end

    // Control and output registers with synchronous active-high reset.
    always_ff @(posedge clk_w5) begin
        if (reset_b) begin
            for (int i = 0; i < NCH; i++) begin
                state[i] <= PARKED;
                q[i]     <= '0;
                half[i]  <= DEF_HALF_C;
            end
            pend_v  <= '0;
            clk_out <= '0;
            tick    <= '0;
            div_ack <= 1'b0;
            div_err <= 1'b0;
        end else begin
            for (int i = 0; i < NCH; i++) begin
                state[i] <= state_nxt[i];
                q[i]     <= q_nxt[i];
                half[i]  <= half_nxt[i];
            end
            pend_v  <= pend_v_nxt;
            clk_out <= clk_nxt;
            tick    <= tick_nxt;
            div_ack <= wr_ok;
            div_err <= div_wr && !wr_ok;
        end
    end

    // Pending divisor data; only meaningful while its pend_v flag is set.
    always_ff @(posedge clk_w5) begin
        for (int i = 0; i < NCH; i++) begin
            pend[i] <= pend_nxt[i];
        end
    end

endmodule

// File: tb/tb_clk_div_multi.sv
// Testbench for clk_div_multi: directed timing sequences, a write-validation
// vector table, and randomized traffic checked against an event-schedule model.
module tb_clk_div_multi;

    localparam int NCH      = 3;
    localparam int CH_W     = 2;
    localparam int CNT_W    = 16;
    localparam int DEF_HALF = 25;

    logic             clk_w5  = 1'b0;
    logic             reset_b = 1'b1;
    logic [NCH-1:0]   en      = '0;
    logic             div_wr  = 1'b0;
    logic [CH_W-1:0]  div_ch  = '0;
    logic [CNT_W-1:0] div_val = '0;
    logic             div_ack;
    logic             div_err;
    logic [NCH-1:0]   clk_out;
    logic [NCH-1:0]   tick;

    int checks   = 0;
    int failures = 0;
    int edge_no  = 0;

    always #5 clk_w5 = ~clk_w5;

    clk_div_multi #(
        .NCH(NCH), .CH_W(CH_W), .CNT_W(CNT_W), .DEF_HALF(DEF_HALF)
    ) dut (
        .clk_w5(clk_w5), .reset_b(reset_b), .en(en),
        .div_wr(div_wr), .div_ch(div_ch), .div_val(div_val),
        .div_ack(div_ack), .div_err(div_err),
        .clk_out(clk_out), .tick(tick)
    );

    // Reference model: each running channel holds the absolute edge number of
    // its next toggle; the divisor is looked up only when scheduling.
    int             mt = 0;
    logic [NCH-1:0] m_run  = '0;
    logic [NCH-1:0] m_lvl  = '0;
    logic [NCH-1:0] m_pv   = '0;
    logic [NCH-1:0] m_tick = '0;
    logic           m_ack  = 1'b0;
    logic           m_err  = 1'b0;
    int             m_next [NCH];
    int             m_half [NCH];
    int             m_pend [NCH];

    function automatic void model_edge();
        mt++;
        m_tick = '0;
        m_ack  = 1'b0;
        m_err  = 1'b0;
        if (reset_b) begin
            m_run = '0;
            m_lvl = '0;
            m_pv  = '0;
            for (int i = 0; i < NCH; i++) m_half[i] = DEF_HALF;
            return;
        end
        for (int i = 0; i < NCH; i++) begin
            if (!m_run[i]) begin
                if (m_pv[i]) begin
                    m_half[i] = m_pend[i];
                    m_pv[i]   = 1'b0;
                end
                if (en[i]) begin
                    m_run[i]  = 1'b1;
                    m_next[i] = mt + m_half[i];
                end
            end else if (!en[i] && !m_lvl[i]) begin
                m_run[i] = 1'b0;
            end else if (mt == m_next[i]) begin
                m_lvl[i] = !m_lvl[i];
                if (m_lvl[i]) begin
                    m_tick[i] = 1'b1;
                end else begin
                    if (m_pv[i]) begin
                        m_half[i] = m_pend[i];
                        m_pv[i]   = 1'b0;
                    end
                    if (!en[i]) m_run[i] = 1'b0;
                end
                m_next[i] = mt + m_half[i];
            end
        end
        if (div_wr) begin
            if (int'(div_ch) < NCH && div_val != 0) begin
                m_pend[int'(div_ch)] = int'(div_val);
                m_pv[int'(div_ch)]   = 1'b1;
                m_ack = 1'b1;
            end else begin
                m_err = 1'b1;
            end
        end
    endfunction

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s at t=%0t edge=%0d: got %0d expected %0d", name, $time, edge_no, act, exp);
        end
    endtask

    // One clock edge: advance the model, then compare every output with it.
    task automatic step();
        @(posedge clk_w5);
        model_edge();
        edge_no++;
        #1;
        chk("model_clk_out", longint'(clk_out), longint'(m_lvl));
        chk("model_tick",    longint'(tick),    longint'(m_tick));
        chk("model_ack",     longint'(div_ack), longint'(m_ack));
        chk("model_err",     longint'(div_err), longint'(m_err));
    endtask

    task automatic do_reset();
        reset_b = 1'b1;
        en      = '0;
        div_wr  = 1'b0;
        step();
        step();
        chk("rst_clk_out", longint'(clk_out), 0);
        chk("rst_tick",    longint'(tick),    0);
        chk("rst_ack",     longint'(div_ack), 0);
        chk("rst_err",     longint'(div_err), 0);
        reset_b = 1'b0;
    endtask

    task automatic do_write(input int ch, input int val);
        div_wr  = 1'b1;
        div_ch  = CH_W'(ch);
        div_val = CNT_W'(val);
        step();
        div_wr  = 1'b0;
    endtask

    // Step until clk_out[ch] reads lvl; at = edge number, or -1 on timeout.
    task automatic wait_level(input int ch, input logic lvl, input int budget, output int at);
        at = -1;
        for (int k = 0; k < budget; k++) begin
            step();
            if (clk_out[ch] == lvl) begin
                at = edge_no;
                break;
            end
        end
    endtask

    typedef struct {
        logic [CH_W-1:0]  ch;
        logic [CNT_W-1:0] val;
        logic             exp_ack;
        logic             exp_err;
    } wr_vec_t;

    wr_vec_t vecs [6];

    initial begin
        int at;
        int highs;

        vecs[0] = '{2'd0, 16'd0, 1'b0, 1'b1};
        vecs[1] = '{2'd3, 16'd5, 1'b0, 1'b1};
        vecs[2] = '{2'd2, 16'd9, 1'b1, 1'b0};
        vecs[3] = '{2'd3, 16'd0, 1'b0, 1'b1};
        vecs[4] = '{2'd1, 16'd0, 1'b0, 1'b1};
        vecs[5] = '{2'd2, 16'd4, 1'b1, 1'b0};

        // Write validation on parked channels; rejected writes leave divisors alone.
        do_reset();
        for (int v = 0; v < 6; v++) begin
            do_write(int'(vecs[v].ch), int'(vecs[v].val));
            chk("vec_ack", longint'(div_ack), longint'(vecs[v].exp_ack));
            chk("vec_err", longint'(div_err), longint'(vecs[v].exp_err));
        end
        step();
        en = '1;
        edge_no = 0;
        wait_level(2, 1'b1, 100, at);
        chk("vec_ch2_rise", at, 5);
        wait_level(0, 1'b1, 100, at);
        chk("vec_ch0_rise", at, 26);
        chk("vec_ch1_high", longint'(clk_out[1]), 1);

        // Default timing, then a mid-high rewrite of channel 1 to 3.
        do_reset();
        en = '1;
        edge_no = 0;
        wait_level(0, 1'b1, 100, at);
        chk("def_rise", at, 26);
        chk("def_tick", longint'(tick[0]), 1);
        wait_level(0, 1'b0, 100, at);
        chk("def_fall", at, 51);
        wait_level(0, 1'b1, 100, at);
        chk("def_rise2", at, 76);
        do_write(1, 3);
        chk("wr3_ack", longint'(div_ack), 1);
        chk("wr3_err", longint'(div_err), 0);
        wait_level(1, 1'b0, 100, at);
        chk("wr3_fall_full", at, 101);
        wait_level(1, 1'b1, 100, at);
        chk("wr3_rise", at, 104);
        wait_level(1, 1'b0, 100, at);
        chk("wr3_fall", at, 107);

        // Drop en in the high phase at q=5, then re-enable.
        do_reset();
        en = 3'b001;
        edge_no = 0;
        wait_level(0, 1'b1, 100, at);
        chk("park_rise", at, 26);
        for (int k = 0; k < 5; k++) step();
        en = '0;
        wait_level(0, 1'b0, 100, at);
        chk("park_fall", at, 51);
        highs = 0;
        for (int k = 0; k < 30; k++) begin
            step();
            if (clk_out[0]) highs++;
        end
        chk("park_held_low", highs, 0);
        en = 3'b001;
        edge_no = 0;
        wait_level(0, 1'b1, 100, at);
        chk("reen_rise", at, 26);

        // Back-to-back writes: last wins; then half-period 1.
        do_reset();
        en = 3'b001;
        edge_no = 0;
        for (int k = 0; k < 9; k++) step();
        do_write(0, 4);
        do_write(0, 7);
        chk("b2b_ack", longint'(div_ack), 1);
        wait_level(0, 1'b1, 100, at);
        chk("b2b_rise", at, 26);
        wait_level(0, 1'b0, 100, at);
        chk("b2b_fall", at, 51);
        wait_level(0, 1'b1, 100, at);
        chk("b2b_rise7", at, 58);
        wait_level(0, 1'b0, 100, at);
        chk("b2b_fall7", at, 65);
        do_write(0, 1);
        wait_level(0, 1'b1, 100, at);
        chk("div1_rise7", at, 72);
        wait_level(0, 1'b0, 100, at);
        chk("div1_fall7", at, 79);
        for (int k = 1; k <= 6; k++) begin
            step();
            chk("div1_clk",  longint'(clk_out[0]), k % 2);
            chk("div1_tick", longint'(tick[0]),    k % 2);
        end

        // Reset mid-period with a pending divisor and a write in the reset cycle.
        do_reset();
        en = 3'b001;
        edge_no = 0;
        wait_level(0, 1'b1, 100, at);
        do_write(0, 3);
        for (int k = 0; k < 3; k++) step();
        reset_b = 1'b1;
        div_wr  = 1'b1;
        div_ch  = '0;
        div_val = 16'd5;
        step();
        chk("midrst_clk",  longint'(clk_out), 0);
        chk("midrst_tick", longint'(tick),    0);
        chk("midrst_ack",  longint'(div_ack), 0);
        chk("midrst_err",  longint'(div_err), 0);
        reset_b = 1'b0;
        div_wr  = 1'b0;
        edge_no = 0;
        wait_level(0, 1'b1, 100, at);
        chk("midrst_rise", at, 26);
        wait_level(0, 1'b0, 100, at);
        chk("midrst_fall", at, 51);

        // Randomized traffic against the model.
        for (int c = 0; c < 4000; c++) begin
            reset_b = ($urandom_range(0, 599) == 0);
            for (int i = 0; i < NCH; i++) begin
                if ($urandom_range(0, 79) == 0) en[i] = ~en[i];
            end
            div_wr  = ($urandom_range(0, 19) == 0);
            div_ch  = CH_W'($urandom_range(0, 3));
            div_val = ($urandom_range(0, 9) == 0) ? '0 : CNT_W'($urandom_range(1, 7));
            step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/clk_div_multi.md
# clk_div_multi

Multi-channel, runtime-programmable clock divider generating NCH independent divided clocks from the 100 MHz board clock. Each channel has a half-period register that software or a control FSM can rewrite. New values take effect only at a period boundary, so no runt pulses occur. Each channel also emits a one-cycle `tick` strobe usable as a clock enable. The block replaces fixed-ratio dividers in the communication front end and feeds UART/SPI timing and the Anubis core's slow-clock domains.

## Interface
Parameters:
- NCH, 2, number of independent divider channels (1..8)
- CH_W, 1, width of channel select; must satisfy 2^CH_W >= NCH
- CNT_W, 16, width of the half-period counter and divisor registers
- DEF_HALF, 25, reset half-period in clk_w5 cycles (25 gives 2 MHz from 100 MHz)

Ports:
- clk_w5  in  1  100 MHz board clock; all logic on its rising edge
- reset_b  in  1  synchronous, active-high reset
- en  in  NCH  per-channel run enable
- div_wr  in  1  one-cycle write strobe for a new half-period
- div_ch  in  CH_W  target channel of the write
- div_val  in  CNT_W  new half-period in clk_w5 cycles (legal 1..2^CNT_W-1)
- div_ack  out  1  one-cycle pulse, the write was accepted
- div_err  out  1  one-cycle pulse, the write was rejected
- clk_out  out  NCH  registered divided clocks, 50% duty
- tick  out  NCH  one-cycle pulse in the cycle clk_out[i] goes 0->1

## Operation
- Each channel i has these registers:
  - q[i]: counter, CNT_W bits.
  - half[i]: active half-period.
  - pend[i], pend_v[i]: pending half-period and its valid flag.
  - clk_out[i].
  - run[i]: running or parked state.
- Reset values:
  - q = 0, clk_out = 0, tick = 0, div_ack = 0, div_err = 0.
  - half = DEF_HALF, pend_v = 0.
  - run = 0 (parked).
- PARKED state:
  - clk_out = 0 and q = 0 are held.
  - If pend_v is set, half <= pend and pend_v <= 0 on the next edge.
  - If en[i] = 1, the channel moves to RUN. Counting starts from q = 0 on that edge.
- RUN state:
  - If q == half-1, then q <= 0 and clk_out toggles. Otherwise q <= q+1.
  - A 0->1 toggle asserts tick[i] in the same cycle.
  - A 1->0 toggle is the period boundary. If pend_v is set, half <= pend and pend_v <= 0 on that edge, and the new value governs the next low phase.
- en[i] deasserted in RUN:
  - If clk_out = 0, the channel parks on the next edge. q <= 0 and the low phase is extended, never shortened into a runt high.
  - If clk_out = 1, the high phase completes at full length. The channel falls at the boundary and parks with q = 0. Any pending divisor is applied at that boundary.
- Divisor write, sampled when div_wr = 1:
  - Accepted if div_ch < NCH and div_val != 0. Then pend[div_ch] <= div_val, pend_v <= 1, and div_ack pulses the following cycle.
  - Otherwise no state changes and div_err pulses the following cycle.
  - If a second write to the same channel arrives before application, the last write wins.
  - div_ack and div_err are never both 1.
- A write landing on the same edge as the 1->0 boundary is not applied at that boundary. It is stored as pending and applied at the next boundary.
- div_val = 1 gives clk_w5/2, with a toggle every cycle.
- Arithmetic:
  - The period is 2*half cycles.
  - The comparison is an equality on CNT_W bits. q never exceeds half-1 because half only changes while q = 0.
- reset_b = 1 at any time, including mid-period or with a write pending, returns all state to reset values on that edge. Writes in that cycle are dropped with no ack and no err.

## Timing
- Let edge 1 be the first edge with reset_b = 0 and en[i] = 1.
  - The channel enters RUN at edge 1.
  - clk_out rises after edge DEF_HALF+1, and tick is high in that cycle.
  - clk_out then falls DEF_HALF edges later.
- All outputs are registered, with no combinational path from inputs to outputs.
- Write-to-ack latency is 1 cycle.
- Write-to-effect latency:
  - Parked channel: 2 cycles.
  - Running channel: up to the next 1->0 boundary.
- Channels are fully independent. Simultaneous boundaries on all channels are legal.

## Test plan
- Reset, en = all 1, defaults: clk_out[0] rises at edge 26, period 50 cycles, tick once per period, duty exactly 25/25.
- Write ch 1 = 3 mid-high phase: div_ack pulses at +1, the current high phase keeps its old length, and after the next fall the period is 6 cycles.
- Writes with div_val = 0 and with div_ch = NCH (NCH < 2^CH_W): div_err pulses, div_ack = 0, divisors unchanged.
- Drop en during the high phase at q = 5 with half = 25: high lasts the full 25 cycles, then clk_out stays 0 with q = 0. Re-enable: rise 26 edges later.
- Two back-to-back writes (4 then 7) to a running channel: 7 takes effect at the boundary and 4 is never seen. With div_val = 1, clk_out toggles every cycle and tick fires every 2 cycles.
- Assert reset_b mid-period with pend_v set: the next edge gives clk_out = 0, q = 0, half = DEF_HALF, pend_v = 0, and no ack or err.
